sublime_voice_sequencer: RTL and testbench

Controller that walks every voice once per output sample and feeds the voice mixer. On each sample tick it requests each voice's sample from the shared voice generator over a req/ack handshake. It pairs the sample with that voice's stored velocity and presents it on the mixer's active_voice* inputs. Voices are swept from NUM_VOICES-1 down to 0, so voice 0 is always last; the mixer closes the sample period on voice 0.

---
 rtl/sublime_voice_sequencer_pkg.sv | 14 +
 rtl/sublime_velocity_regs.sv | 28 ++
 rtl/sublime_voice_sequencer.sv | 151 +++++++++++++++
 tb/tb_sublime_voice_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sublime_voice_sequencer_pkg.sv
// Shared types and widths for the voice sequencer: FSM encoding and datapath sizes.
package sublime_voice_sequencer_pkg;
  localparam int DEF_NUM_VOICES  = 8;
  localparam int DEF_ACK_TIMEOUT = 64;
  localparam int VOICE_W         = $clog2(DEF_NUM_VOICES);
  localparam int VEL_W           = 8;
  localparam int SMP_W           = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EMIT = 2'd2
  } seq_state_e;
endpackage

// File: rtl/sublime_velocity_regs.sv
// Per-voice velocity register file: one write port, combinational read.
// A write lands on the next edge, so a same-cycle read returns the old value.
module sublime_velocity_regs
  import sublime_voice_sequencer_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int VW         = $clog2(NUM_VOICES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [VW-1:0]    waddr_i,
  input  logic [VEL_W-1:0] wdata_i,
  input  logic [VW-1:0]    raddr_i,
  output logic [VEL_W-1:0] rdata_o
);
  logic [NUM_VOICES-1:0][VEL_W-1:0] vel_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vel_q <= '0;
    end else if (we_i) begin
      vel_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = vel_q[raddr_i];
endmodule

// File: rtl/sublime_voice_sequencer.sv
// Sweeps voices NUM_VOICES-1..0 per sample tick, fetching each over req/ack and strobing it to the mixer.
// Ack-to-strobe latency 1 cycle; a stalled generator is bounded by ACK_TIMEOUT, after which silence is emitted.
module sublime_voice_sequencer
  import sublime_voice_sequencer_pkg::*;
#(
  parameter int NUM_VOICES  = DEF_NUM_VOICES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          sample_tick_i,
  input  logic                          vel_we_i,
  input  logic [$clog2(NUM_VOICES)-1:0] vel_addr_i,
  input  logic [VEL_W-1:0]              vel_data_i,
  output logic                          voice_req_o,
  output logic [$clog2(NUM_VOICES)-1:0] voice_sel_o,
  input  logic                          voice_ack_i,
  input  logic [SMP_W-1:0]              voice_data_i,
  output logic [$clog2(NUM_VOICES)-1:0] active_voice_o,
  output logic                          active_voice_changed_o,
  output logic [VEL_W-1:0]              active_voice_velocity_o,
  output logic [SMP_W-1:0]              active_voice_data_o,
  output logic                          busy_o,
  output logic                          overrun_o,
  output logic                          timeout_err_o,
  input  logic                          err_clr_i
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  seq_state_e       state_q, state_d;
  logic [VW-1:0]    cur_q, cur_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             req_q, req_d;
  logic [VW-1:0]    sel_q, sel_d;
  logic [VW-1:0]    av_q, av_d;
  logic             chg_q, chg_d;
  logic [VEL_W-1:0] vel_q, vel_d;
  logic [SMP_W-1:0] dat_q, dat_d;
  logic             ovr_q, ovr_d;
  logic             tmo_q, tmo_d;
  logic [VEL_W-1:0] vel_rd;
  logic             timed_out;

  sublime_velocity_regs #(.NUM_VOICES(NUM_VOICES), .VW(VW)) u_vel (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (vel_we_i),
    .waddr_i (vel_addr_i),
    .wdata_i (vel_data_i),
    .raddr_i (cur_q),
    .rdata_o (vel_rd)
  );

  // Final waiting cycle without an ack: give up on this voice.
  assign timed_out = (state_q == ST_REQ) && !voice_ack_i && (tmr_q == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      tmr_q   <= '0;
      req_q   <= 1'b0;
      sel_q   <= '0;
      av_q    <= '0;
      chg_q   <= 1'b0;
      vel_q   <= '0;
      dat_q   <= '0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tmr_q   <= tmr_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      av_q    <= av_d;
      chg_q   <= chg_d;
      vel_q   <= vel_d;
      dat_q   <= dat_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (sample_tick_i) state_d = ST_REQ;
      ST_REQ:  if (voice_ack_i || timed_out) state_d = ST_EMIT;
      ST_EMIT: state_d = (cur_q == '0) ? ST_IDLE : ST_REQ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_d = cur_q;
    tmr_d = '0;
    req_d = req_q;
    sel_d = sel_q;
    av_d  = av_q;
    chg_d = 1'b0;
    vel_d = vel_q;
    dat_d = dat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sample_tick_i) begin
          cur_d = VW'(NUM_VOICES - 1);
          req_d = 1'b1;
          sel_d = VW'(NUM_VOICES - 1);
        end
      end
      ST_REQ: begin
        if (voice_ack_i || timed_out) begin
          av_d  = cur_q;
          vel_d = vel_rd;
          dat_d = voice_ack_i ? voice_data_i : '0;
          chg_d = 1'b1;
          req_d = 1'b0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_EMIT: begin
        if (cur_q != '0) begin
          cur_d = cur_q - VW'(1);
          req_d = 1'b1;
          sel_d = cur_q - VW'(1);
        end
      end
      default: ;
    endcase
    // A clear wins over any set arriving in the same cycle.
    ovr_d = ovr_q | (sample_tick_i && (state_q != ST_IDLE));
    tmo_d = tmo_q | timed_out;
    if (err_clr_i) begin
      ovr_d = 1'b0;
      tmo_d = 1'b0;
    end
  end

  assign voice_req_o             = req_q;
  assign voice_sel_o             = sel_q;
  assign active_voice_o          = av_q;
  assign active_voice_changed_o  = chg_q;
  assign active_voice_velocity_o = vel_q;
  assign active_voice_data_o     = dat_q;
  assign busy_o                  = (state_q != ST_IDLE);
  assign overrun_o               = ovr_q;
  assign timeout_err_o           = tmo_q;
endmodule

// File: tb/tb_sublime_voice_sequencer.sv
// Directed bench for the voice sequencer: table-checked basic sweep plus hand-written corner sequences.
module tb_sublime_voice_sequencer;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sample_tick = 1'b0;
  logic        vel_we = 1'b0;
  logic [2:0]  vel_addr = '0;
  logic [7:0]  vel_data = '0;
  logic        voice_req;
  logic [2:0]  voice_sel;
  logic        voice_ack = 1'b0;
  logic [31:0] voice_data = '0;
  logic [2:0]  active_voice;
  logic        active_voice_changed;
  logic [7:0]  active_voice_velocity;
  logic [31:0] active_voice_data;
  logic        busy;
  logic        overrun;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  sublime_voice_sequencer #(.NUM_VOICES(8), .ACK_TIMEOUT(64)) dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_ni),
    .sample_tick_i           (sample_tick),
    .vel_we_i                (vel_we),
    .vel_addr_i              (vel_addr),
    .vel_data_i              (vel_data),
    .voice_req_o             (voice_req),
    .voice_sel_o             (voice_sel),
    .voice_ack_i             (voice_ack),
    .voice_data_i            (voice_data),
    .active_voice_o          (active_voice),
    .active_voice_changed_o  (active_voice_changed),
    .active_voice_velocity_o (active_voice_velocity),
    .active_voice_data_o     (active_voice_data),
    .busy_o                  (busy),
    .overrun_o               (overrun),
    .timeout_err_o           (timeout_err),
    .err_clr_i               (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          voice;
    logic [7:0]  vel;
    logic [31:0] data;
    int          rel;
  } exp_t;

  typedef struct {
    int          voice;
    logic [7:0]  vel;
    logic [31:0] data;
    int          cyc;
    logic        tmo;
  } mon_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   base = 0;
  int   tick_at1 = -1;
  int   tick_at2 = -1;
  int   req_cnt = 0;
  int   proto_err = 0;
  int   ack_dly[8];
  bit   no_ack[8];
  int   req_len[8];
  bit   prev_req = 1'b0;
  logic [2:0] prev_sel = '0;
  bit   wr_arm = 1'b0;
  bit   wr_pulse = 1'b0;
  mon_t mon_q[$];
  exp_t basic[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: observe outputs #1 after the edge, then act as the voice generator.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (active_voice_changed)
      mon_q.push_back('{int'(active_voice), active_voice_velocity, active_voice_data, cyc, timeout_err});
    if (active_voice_changed && voice_req) proto_err++;
    if (prev_req && voice_req && voice_sel != prev_sel) proto_err++;
    prev_req = voice_req;
    prev_sel = voice_sel;
    req_cnt = voice_req ? req_cnt + 1 : 0;
    if (voice_req) req_len[voice_sel] = req_cnt;
    if (wr_pulse) begin
      vel_we = 1'b0;
      wr_pulse = 1'b0;
    end
    voice_ack = voice_req && (req_cnt > ack_dly[voice_sel]) && !no_ack[voice_sel];
    voice_data = voice_ack ? 32'h1000 + 32'(voice_sel) : 32'hDEAD_BEEF;
    if (wr_arm && voice_ack && voice_sel == 3'd5) begin
      vel_we = 1'b1;
      vel_addr = 3'd5;
      vel_data = 8'hFF;
      wr_arm = 1'b0;
      wr_pulse = 1'b1;
    end
    sample_tick = (cyc == tick_at1) || (cyc == tick_at2);
    err_clr = 1'b0;
  endtask

  task automatic write_vel(input logic [2:0] a, input logic [7:0] d);
    vel_we = 1'b1;
    vel_addr = a;
    vel_data = d;
    step();
    vel_we = 1'b0;
  endtask

  task automatic run_sweep(input int budget, output int bcyc);
    mon_q.delete();
    base = cyc;
    sample_tick = 1'b1;
    step();
    bcyc = 0;
    while (busy && bcyc < budget) begin
      bcyc++;
      step();
    end
    check("sweep_ends", 32'(busy), 32'd0);
  endtask

  task automatic check_order(input string name);
    check({name, "_count"}, 32'(mon_q.size()), 32'd8);
    for (int i = 0; i < mon_q.size() && i < 8; i++)
      check({name, "_voice"}, 32'(mon_q[i].voice), 32'(7 - i));
  endtask

  initial begin
    int bc;
    basic[0] = '{7, 8'h70, 32'h1007, 2};
    basic[1] = '{6, 8'h60, 32'h1006, 4};
    basic[2] = '{5, 8'h50, 32'h1005, 6};
    basic[3] = '{4, 8'h40, 32'h1004, 8};
    basic[4] = '{3, 8'h30, 32'h1003, 10};
    basic[5] = '{2, 8'h20, 32'h1002, 12};
    basic[6] = '{1, 8'h10, 32'h1001, 14};
    basic[7] = '{0, 8'h00, 32'h1000, 16};
    for (int i = 0; i < 8; i++) begin
      ack_dly[i] = 0;
      no_ack[i] = 1'b0;
      req_len[i] = 0;
    end

    step();
    step();
    check("rst_req", 32'(voice_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_changed", 32'(active_voice_changed), 32'd0);
    check("rst_data", active_voice_data, 32'd0);
    check("rst_flags", {30'd0, overrun, timeout_err}, 32'd0);
    rst_ni = 1'b1;
    step();

    for (int i = 0; i < 8; i++) write_vel(3'(i), 8'(i * 16));

    // Immediate acks, checked against the table.
    run_sweep(100, bc);
    check("basic_busy_cycles", 32'(bc), 32'd16);
    check("basic_count", 32'(mon_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < mon_q.size(); i++) begin
      check("basic_voice", 32'(mon_q[i].voice), 32'(basic[i].voice));
      check("basic_vel", 32'(mon_q[i].vel), 32'(basic[i].vel));
      check("basic_data", mon_q[i].data, basic[i].data);
      check("basic_cycle", 32'(mon_q[i].cyc - base), 32'(basic[i].rel));
    end
    check("basic_flags", {30'd0, overrun, timeout_err}, 32'd0);
    check("hold_voice", 32'(active_voice), 32'd0);
    check("hold_data", active_voice_data, 32'h1000);

    // Voice 4 acked 5 cycles late.
    ack_dly[4] = 5;
    run_sweep(100, bc);
    ack_dly[4] = 0;
    check("delay_busy_cycles", 32'(bc), 32'd21);
    check("delay_req_len", 32'(req_len[4]), 32'd6);
    check_order("delay");
    if (mon_q.size() == 8) begin
      check("delay_strobe_gap", 32'(mon_q[3].cyc - mon_q[2].cyc), 32'd7);
      check("delay_v4_data", mon_q[3].data, 32'h1004);
    end

    // Voice 2 never acks: timeout emits silence.
    no_ack[2] = 1'b1;
    run_sweep(300, bc);
    no_ack[2] = 1'b0;
    check("tmo_busy_cycles", 32'(bc), 32'd79);
    check("tmo_req_len", 32'(req_len[2]), 32'd64);
    check_order("tmo");
    if (mon_q.size() == 8) begin
      check("tmo_v3_flag", 32'(mon_q[4].tmo), 32'd0);
      check("tmo_v2_data", mon_q[5].data, 32'd0);
      check("tmo_v2_vel", 32'(mon_q[5].vel), 32'h20);
      check("tmo_v2_flag", 32'(mon_q[5].tmo), 32'd1);
      check("tmo_v1_data", mon_q[6].data, 32'h1001);
      check("tmo_v0_data", mon_q[7].data, 32'h1000);
    end
    check("tmo_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    step();
    check("tmo_cleared", 32'(timeout_err), 32'd0);

    // Ticks mid-sweep and on the voice-0 strobe are ignored but flagged.
    tick_at1 = cyc + 5;
    tick_at2 = cyc + 16;
    run_sweep(100, bc);
    tick_at1 = -1;
    tick_at2 = -1;
    check("ovr_busy_cycles", 32'(bc), 32'd16);
    check_order("ovr");
    check("ovr_set", 32'(overrun), 32'd1);
    err_clr = 1'b1;
    run_sweep(100, bc);
    check("ovr_next_busy", 32'(bc), 32'd16);
    check_order("ovr_next");
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Velocity write coincident with voice 5 capture.
    write_vel(3'd5, 8'h20);
    wr_arm = 1'b1;
    run_sweep(100, bc);
    if (mon_q.size() == 8) begin
      check("velwr_old", 32'(mon_q[2].vel), 32'h20);
      check("velwr_v4", 32'(mon_q[3].vel), 32'h40);
    end
    run_sweep(100, bc);
    if (mon_q.size() == 8) check("velwr_new", 32'(mon_q[2].vel), 32'hFF);

    // Reset while requesting voice 6.
    sample_tick = 1'b1;
    step();
    step();
    step();
    check("mid_req", 32'(voice_req), 32'd1);
    check("mid_sel", 32'(voice_sel), 32'd6);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_req", 32'(voice_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_voice", 32'(active_voice), 32'd0);
    check("mid_rst_vel", 32'(active_voice_velocity), 32'd0);
    check("mid_rst_data", active_voice_data, 32'd0);
    mon_q.delete();
    step();
    step();
    rst_ni = 1'b1;
    step();
    step();
    step();
    check("post_rst_no_strobe", 32'(mon_q.size()), 32'd0);
    run_sweep(100, bc);
    check("post_rst_busy", 32'(bc), 32'd16);
    check_order("post_rst");
    for (int i = 0; i < 8 && i < mon_q.size(); i++) begin
      check("post_rst_vel", 32'(mon_q[i].vel), 32'd0);
      check("post_rst_data", mon_q[i].data, 32'h1000 + 32'(7 - i));
    end

    check("protocol", 32'(proto_err), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
